obi_cmd_queue_interface: RTL
============================

Name: obi_cmd_queue_interface

Overview:
- Next-generation OBI slave front-end for the cache controller.
- Requests are staged in a word-addressed register window, then issued to the controller through a queued valid/ready command port.
- Up to CMD_DEPTH commands may be outstanding at once.
- The most recent completion is latched into a readable result/status window.
- Byte enables, unmapped-address errors and ID echo are supported. Single-cycle OBI responses are always produced.

Parameters:
- DATA_WIDTH, 32: OBI data width. Power of two, at least 16.
- ADDR_WIDTH, 8: OBI byte address width.
- ID_WIDTH, 3: OBI aid/rid width.
- KEY_WIDTH, 32: controller key width. Must be a multiple of DATA_WIDTH.
- VALUE_WIDTH, 64: controller value width. Must be a multiple of DATA_WIDTH.
- OP_WIDTH, 3: operation code width. Must be at most DATA_WIDTH.
- NOOP_CODE, 0: op code that is accepted but never enqueued.
- CMD_DEPTH, 4: maximum outstanding commands. At least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- obi_req  in  1  OBI request
- obi_gnt  out  1  OBI grant (combinational)
- obi_addr  in  ADDR_WIDTH  byte address
- obi_we  in  1  1 = write
- obi_be  in  DATA_WIDTH/8  byte enables
- obi_wdata  in  DATA_WIDTH  write data
- obi_aid  in  ID_WIDTH  request ID
- obi_rvalid  out  1  response valid
- obi_rdata  out  DATA_WIDTH  read data
- obi_rid  out  ID_WIDTH  response ID
- obi_err  out  1  response error
- cmd_valid  out  1  command valid to controller
- cmd_ready  in  1  controller accepts command
- cmd_op  out  OP_WIDTH  operation code
- cmd_key  out  KEY_WIDTH  key
- cmd_value  out  VALUE_WIDTH  value
- rsp_valid  in  1  controller completion strobe (in order, one per command)
- rsp_succ  in  1  completion success
- rsp_value  in  VALUE_WIDTH  completion data

Behaviour:
- Word index: W = obi_addr >> log2(DATA_WIDTH/8). Define NV = VALUE_WIDTH/DATA_WIDTH and NK = KEY_WIDTH/DATA_WIDTH.
- Address map:
  - W 0..NV-1: staging value (RW)
  - W NV..NV+NK-1: staging key (RW)
  - W NV+NK: OP (W; reads 0)
  - W NV+NK+1: STATUS (R)
  - W NV+NK+2..NV+NK+1+NV: result value (R)
  - all other W: unmapped
- Staging writes update only the bytes enabled by obi_be. Staging contents persist after a command is issued.
- OP write with wdata[OP_WIDTH-1:0] != NOOP_CODE pushes {op, key, value} into the command FIFO (depth CMD_DEPTH) and increments the pending count.
- OP write with NOOP_CODE is accepted with no other effect.
- Grant: obi_gnt = !(obi_req && obi_we && W == OP && op != NOOP_CODE && pending == CMD_DEPTH). Otherwise obi_gnt = 1, including while obi_req is low.
- Handshake: a request is accepted when obi_req && obi_gnt. The response appears in the next cycle: obi_rvalid = 1 for exactly one cycle, obi_rid = the registered aid. There is no rready; the master must always accept.
- Response contents:
  - Write response: obi_rdata = 0.
  - Read response: obi_rdata = the addressed word as of the accept cycle.
- Unmapped access, or a write to a read-only word: obi_err = 1, obi_rdata = 0, no side effect. In all other cases obi_err = 0.
- STATUS word:
  - bit0 done
  - bit1 result_err
  - bits[15:8] pending count, zero-extended
  - all other bits 0
- A STATUS read clears done. If rsp_valid occurs in the same cycle, done stays 1 (set wins).
- Controller handshake:
  - cmd_valid = FIFO not empty. cmd_op/key/value are driven from the FIFO head and are stable while cmd_valid && !cmd_ready.
  - A pop occurs on cmd_valid && cmd_ready.
  - Push and pop in the same cycle are both honoured. When the FIFO is empty, a push is visible on cmd_valid in the next cycle (no bypass).
- Pending count: +1 on enqueue, -1 on rsp_valid, unchanged if both occur in the same cycle. rsp_valid with pending == 0 is ignored entirely and leaves result and done unchanged.
- On rsp_valid: result <= rsp_value, result_err <= !rsp_succ, done <= 1.
- Reset (any cycle, including mid-transfer or with commands queued):
  - FIFO, pending, staging, result, done and result_err are cleared to 0.
  - obi_rvalid = 0, obi_rdata = 0, obi_rid = 0, obi_err = 0, cmd_valid = 0.
  - A request presented while rst is high is not accepted and gets no response.

Test Plan:
(Defaults; byte addresses: value 0x00/0x04, key 0x08, OP 0x0C, STATUS 0x10, result 0x14/0x18.)
- Write 0x00=0xDEADBEEF, 0x04=0x01234567, 0x08=0x00000042, aid=5, then write OP=2 → each write gets rvalid next cycle with rid=5 and err=0; cmd_valid rises with cmd_op=2, cmd_key=0x42, cmd_value=0x01234567_DEADBEEF.
- Hold cmd_ready=0 and issue 5 OP=1 writes → first 4 granted, STATUS read gives bits[15:8]=4, fifth OP write sees gnt=0 until rsp_valid arrives, then is granted.
- rsp_valid with rsp_succ=0 and rsp_value=0x0000_00AA_0000_0055 → STATUS=0x0X03 (done and err set); reads 0x14=0x55 and 0x18=0xAA; a second STATUS read has bit0=0.
- Write 0x00=0xFFFFFFFF with be=4'b0010 after reset → readback 0x0000FF00.
- Read 0x3C and write 0x10 → err=1, rdata=0, and neither state nor the FIFO changes.
- Assert rst with 3 commands queued → next cycle cmd_valid=0, STATUS=0, and staging reads 0.

Source files
------------

// File: rtl/obi_cmd_queue_interface.sv
// OBI slave front-end for the cache controller: staging window, queued command port
// toward the controller, and a result/status window holding the latest completion.
module obi_cmd_queue_interface #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int ID_WIDTH    = 3,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 64,
    parameter int OP_WIDTH    = 3,
    parameter int NOOP_CODE   = 0,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    obi_req,
    output logic                    obi_gnt,
    input  logic [ADDR_WIDTH-1:0]   obi_addr,
    input  logic                    obi_we,
    input  logic [DATA_WIDTH/8-1:0] obi_be,
    input  logic [DATA_WIDTH-1:0]   obi_wdata,
    input  logic [ID_WIDTH-1:0]     obi_aid,
    output logic                    obi_rvalid,
    output logic [DATA_WIDTH-1:0]   obi_rdata,
    output logic [ID_WIDTH-1:0]     obi_rid,
    output logic                    obi_err,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [OP_WIDTH-1:0]     cmd_op,
    output logic [KEY_WIDTH-1:0]    cmd_key,
    output logic [VALUE_WIDTH-1:0]  cmd_value,
    input  logic                    rsp_valid,
    input  logic                    rsp_succ,
    input  logic [VALUE_WIDTH-1:0]  rsp_value
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int WB = $clog2(NB);
    localparam int NV = VALUE_WIDTH / DATA_WIDTH;
    localparam int NK = KEY_WIDTH / DATA_WIDTH;
    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = $clog2(CMD_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] W_KEY  = ADDR_WIDTH'(NV);
    localparam logic [ADDR_WIDTH-1:0] W_OP   = ADDR_WIDTH'(NV + NK);
    localparam logic [ADDR_WIDTH-1:0] W_STAT = ADDR_WIDTH'(NV + NK + 1);
    localparam logic [ADDR_WIDTH-1:0] W_RES  = ADDR_WIDTH'(NV + NK + 2);
    localparam logic [ADDR_WIDTH-1:0] W_END  = ADDR_WIDTH'(NV + NK + 2 + NV);

    logic [DATA_WIDTH-1:0] val_q [NV];
    logic [DATA_WIDTH-1:0] key_q [NK];
    logic [DATA_WIDTH-1:0] res_q [NV];
    logic                  done_q, res_err_q;
    logic [CW-1:0]         pending_q, fifo_cnt_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;

    logic [OP_WIDTH-1:0]    fifo_op    [CMD_DEPTH];
    logic [KEY_WIDTH-1:0]   fifo_key   [CMD_DEPTH];
    logic [VALUE_WIDTH-1:0] fifo_value [CMD_DEPTH];

    logic [ADDR_WIDTH-1:0]  widx;
    logic                   sel_val, sel_key, sel_op, sel_stat, sel_res, bad_access;
    logic                   op_live, accept, enq, deq, push, pop;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [KEY_WIDTH-1:0]   stage_key;
    logic [VALUE_WIDTH-1:0] stage_value;

    assign widx       = obi_addr >> WB;
    assign sel_val    = widx < W_KEY;
    assign sel_key    = (widx >= W_KEY) && (widx < W_OP);
    assign sel_op     = widx == W_OP;
    assign sel_stat   = widx == W_STAT;
    assign sel_res    = (widx >= W_RES) && (widx < W_END);
    assign bad_access = !(sel_val || sel_key || sel_op || sel_stat || sel_res)
                      || (obi_we && (sel_stat || sel_res));
    assign op_live    = obi_wdata[OP_WIDTH-1:0] != OP_WIDTH'(NOOP_CODE);

    assign obi_gnt = !(obi_req && obi_we && sel_op && op_live && (pending_q == CW'(CMD_DEPTH)));
    assign accept  = obi_req && obi_gnt;
    assign enq     = accept && obi_we && sel_op && op_live;
    assign deq     = rsp_valid && (pending_q != '0);

    assign cmd_valid = fifo_cnt_q != '0;
    assign pop       = cmd_valid && cmd_ready;
    // A controller that completes commands it has not yet popped can leave the FIFO full
    // while pending has room; such a push is dropped instead of overwriting the head.
    assign push      = enq && ((fifo_cnt_q != CW'(CMD_DEPTH)) || pop);

    assign cmd_op    = fifo_op[rd_ptr_q];
    assign cmd_key   = fifo_key[rd_ptr_q];
    assign cmd_value = fifo_value[rd_ptr_q];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_word     = '0;
        stage_key   = '0;
        stage_value = '0;
        for (int i = 0; i < NV; i++) begin
            stage_value[i*DATA_WIDTH +: DATA_WIDTH] = val_q[i];
            if (widx == ADDR_WIDTH'(i)) rd_word = val_q[i];
            if (widx == ADDR_WIDTH'(NV + NK + 2 + i)) rd_word = res_q[i];
        end
        for (int i = 0; i < NK; i++) begin
            stage_key[i*DATA_WIDTH +: DATA_WIDTH] = key_q[i];
            if (widx == ADDR_WIDTH'(NV + i)) rd_word = key_q[i];
        end
        if (sel_stat) begin
            rd_word[0]    = done_q;
            rd_word[1]    = res_err_q;
            rd_word[15:8] = 8'(pending_q);
        end
    end

    // NOTE: FIFO storage carries no reset; emptiness is tracked by fifo_cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr_q]    <= obi_wdata[OP_WIDTH-1:0];
            fifo_key[wr_ptr_q]   <= stage_key;
            fifo_value[wr_ptr_q] <= stage_value;
        end
    end

    // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                val_q[i] <= '0;
                res_q[i] <= '0;
            end
            for (int i = 0; i < NK; i++) key_q[i] <= '0;
            done_q     <= 1'b0;
            res_err_q  <= 1'b0;
            pending_q  <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            obi_rvalid <= 1'b0;
            obi_rdata  <= '0;
            obi_rid    <= '0;
            obi_err    <= 1'b0;
        end else begin
            obi_rvalid <= accept;
            obi_err    <= accept && bad_access;
            obi_rdata  <= (accept && !obi_we && !bad_access) ? rd_word : '0;
            if (accept) obi_rid <= obi_aid;

            if (accept && obi_we && !bad_access) begin
                for (int i = 0; i < NV; i++)
                    for (int b = 0; b < NB; b++)
                        if (widx == ADDR_WIDTH'(i) && obi_be[b])
                            val_q[i][b*8 +: 8] <= obi_wdata[b*8 +: 8];
                for (int i = 0; i < NK; i++)
                    for (int b = 0; b < NB; b++)
                        if (widx == ADDR_WIDTH'(NV + i) && obi_be[b])
                            key_q[i][b*8 +: 8] <= obi_wdata[b*8 +: 8];
            end

            if (push) wr_ptr_q <= bump(wr_ptr_q);
            if (pop)  rd_ptr_q <= bump(rd_ptr_q);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: ;
            endcase
            case ({enq, deq})
                2'b10:   pending_q <= pending_q + 1'b1;
                2'b01:   pending_q <= pending_q - 1'b1;
                default: ;
            endcase

            if (deq) begin
                for (int i = 0; i < NV; i++) res_q[i] <= rsp_value[i*DATA_WIDTH +: DATA_WIDTH];
                res_err_q <= !rsp_succ;
                done_q    <= 1'b1;
            end else if (accept && !obi_we && sel_stat) begin
                done_q <= 1'b0;
            end
        end
    end
endmodule
